// File: rtl/nfc_atom_cmd_addr_sequencer.sv
// ---------------------------------------------------------------------------
// nfc_atom_cmd_addr_sequencer
//
// Atomic command/address sequencer. Accepts one latched CA request (a command
// byte or 1-5 address bytes) and drives the NAND CE_n/CLE/ALE/WE_n/DQ pins
// with programmable tWP / tWH / post-sequence timing. Ready and a one-cycle
// LastStep are returned to the issuing command FSM.
//
// Ports:
//   iSystemClock  clock
//   iReset        synchronous reset, active-low
//   iStart        request (ACG command vector bit 3), taken only in IDLE
//   oReady        request may be accepted
//   oLastStep     one-cycle pulse when the sequence has completed
//   iTargetWay    one-hot way select (NumberOfWays bits)
//   iCASelect     1 = command byte (CLE), 0 = address bytes (ALE)
//   iCAData       up to five bytes, [39:32] sent first
//   iNumOfData    address byte count minus 1 (saturates at 5 bytes)
//   oPO_CE_n      chip enables, active-low
//   oPO_CLE       command latch enable
//   oPO_ALE       address latch enable
//   oPO_WE_n      write enable, active-low
//   oPO_DQ        data bus
//   oPO_DQ_OE     data bus output enable
//
// Optional feature macro: NFC_ACS_CE_HOLD_EN
//   When defined, CE_n of the last way stays asserted through DONE/IDLE until
//   reset or until a request to a different way; such a request gets one
//   extra SETUP cycle with all CE_n released.
// ---------------------------------------------------------------------------
module nfc_atom_cmd_addr_sequencer #(
    parameter int NumberOfWays = 4,
    parameter int WP_CYCLES    = 2,
    parameter int WH_CYCLES    = 2,
    parameter int POST_CYCLES  = 4
) (
    input  logic                    iSystemClock,
    input  logic                    iReset,
    input  logic                    iStart,
    output logic                    oReady,
    output logic                    oLastStep,
    input  logic [NumberOfWays-1:0] iTargetWay,
    input  logic                    iCASelect,
    input  logic [39:0]             iCAData,
    input  logic [2:0]              iNumOfData,
    output logic [NumberOfWays-1:0] oPO_CE_n,
    output logic                    oPO_CLE,
    output logic                    oPO_ALE,
    output logic                    oPO_WE_n,
    output logic [7:0]              oPO_DQ,
    output logic                    oPO_DQ_OE
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WE_LOW,
        WE_HIGH,
        HOLD,
        DONE
    } state_t;

    localparam logic [5:0] WP_LOAD   = 6'(WP_CYCLES);
    localparam logic [5:0] WH_LOAD   = 6'(WH_CYCLES);
    localparam logic [5:0] POST_LOAD = 6'(POST_CYCLES);

    state_t                  state;
    logic [5:0]              phase;
    logic [2:0]              byte_idx;
    logic [2:0]              last_idx;
    logic [NumberOfWays-1:0] way;
    logic                    ca_sel;
    logic [39:0]             ca_data;
    logic [7:0]              cur_byte;
    logic [5:0]              setup_load;
    logic [NumberOfWays-1:0] ce_idle;
    logic [NumberOfWays-1:0] ce_setup;

`ifdef NFC_ACS_CE_HOLD_EN
    logic [NumberOfWays-1:0] held_way;
`endif

    // Byte 0 is the most significant byte of the request.
    always_comb begin
        cur_byte = ca_data[7:0];
        case (byte_idx)
            3'd0:    cur_byte = ca_data[39:32];
            3'd1:    cur_byte = ca_data[31:24];
            3'd2:    cur_byte = ca_data[23:16];
            3'd3:    cur_byte = ca_data[15:8];
            default: cur_byte = ca_data[7:0];
        endcase
    end

`ifdef NFC_ACS_CE_HOLD_EN
    // A switch away from a still-held way needs one extra SETUP cycle in which
    // every CE_n is released, so two ways are never enabled back to back.
    always_comb begin
        setup_load = 6'd1;
        if (held_way != '0 && held_way != iTargetWay) begin
            setup_load = 6'd2;
        end
        ce_idle  = ~held_way;
        ce_setup = (phase == 6'd2) ? '1 : ~way;
    end
`else
    always_comb begin
        setup_load = 6'd1;
        ce_idle    = '1;
        ce_setup   = ~way;
    end
`endif

    // Pin outputs are decoded from the state held before each edge, so every
    // pin lags the state register by one cycle; this keeps all outputs
    // registered while the byte index and WE_n still move on the same edge.
    always_ff @(posedge iSystemClock) begin
        if (!iReset) begin
            state     <= IDLE;
            phase     <= 6'd1;
            byte_idx  <= '0;
            last_idx  <= '0;
            way       <= '0;
            ca_sel    <= 1'b0;
            ca_data   <= '0;
`ifdef NFC_ACS_CE_HOLD_EN
            held_way  <= '0;
`endif
            oReady    <= 1'b1;
            oLastStep <= 1'b0;
            oPO_CE_n  <= '1;
            oPO_CLE   <= 1'b0;
            oPO_ALE   <= 1'b0;
            oPO_WE_n  <= 1'b1;
            oPO_DQ    <= 8'h00;
            oPO_DQ_OE <= 1'b0;
        end else begin
            // Output decode
            oReady    <= (state == IDLE);
            oLastStep <= (state == DONE);
            oPO_CE_n  <= ce_idle;
            oPO_CLE   <= 1'b0;
            oPO_ALE   <= 1'b0;
            oPO_WE_n  <= 1'b1;
            oPO_DQ    <= 8'h00;
            oPO_DQ_OE <= 1'b0;
            case (state)
                SETUP: begin
                    oPO_CE_n  <= ce_setup;
                    oPO_CLE   <= ca_sel;
                    oPO_ALE   <= ~ca_sel;
                    oPO_DQ    <= cur_byte;
                    oPO_DQ_OE <= 1'b1;
                end
                WE_LOW: begin
                    oPO_CE_n  <= ~way;
                    oPO_CLE   <= ca_sel;
                    oPO_ALE   <= ~ca_sel;
                    oPO_WE_n  <= 1'b0;
                    oPO_DQ    <= cur_byte;
                    oPO_DQ_OE <= 1'b1;
                end
                WE_HIGH: begin
                    oPO_CE_n  <= ~way;
                    oPO_CLE   <= ca_sel;
                    oPO_ALE   <= ~ca_sel;
                    oPO_DQ    <= cur_byte;
                    oPO_DQ_OE <= 1'b1;
                end
                HOLD: begin
                    oPO_CE_n  <= ~way;
                end
                default: ;
            endcase

            // Sequencing
            case (state)
                IDLE: begin
                    if (iStart) begin
                        way      <= iTargetWay;
                        ca_sel   <= iCASelect;
                        ca_data  <= iCAData;
                        byte_idx <= '0;
                        last_idx <= iCASelect ? 3'd0 :
                                    ((iNumOfData > 3'd4) ? 3'd4 : iNumOfData);
                        phase    <= setup_load;
`ifdef NFC_ACS_CE_HOLD_EN
                        held_way <= iTargetWay;
`endif
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase == 6'd1) begin
                        phase <= WP_LOAD;
                        state <= WE_LOW;
                    end else begin
                        phase <= phase - 6'd1;
                    end
                end
                WE_LOW: begin
                    if (phase == 6'd1) begin
                        phase <= WH_LOAD;
                        state <= WE_HIGH;
                    end else begin
                        phase <= phase - 6'd1;
                    end
                end
                WE_HIGH: begin
                    if (phase == 6'd1) begin
                        if (byte_idx != last_idx) begin
                            byte_idx <= byte_idx + 3'd1;
                            phase    <= WP_LOAD;
                            state    <= WE_LOW;
                        end else begin
                            phase <= POST_LOAD;
                            state <= HOLD;
                        end
                    end else begin
                        phase <= phase - 6'd1;
                    end
                end
                HOLD: begin
                    if (phase == 6'd1) begin
                        phase <= 6'd1;
                        state <= DONE;
                    end else begin
                        phase <= phase - 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nfc_atom_cmd_addr_sequencer.md
Name: nfc_atom_cmd_addr_sequencer

Overview:
- Atomic command/address sequencer (ACS, command-vector bit 3) directly downstream of the NFC command FSMs (reset, get/set feature, read, program).
- Takes one latched CA request (command byte, or 1-5 address bytes) and drives the NAND CE_n/CLE/ALE/WE_n/DQ pins with programmable timing.
- Returns Ready and a one-cycle LastStep to the issuing FSM.

Parameters:
- NumberOfWays, 4, number of target ways; width of the way select and CE_n.
- WP_CYCLES, 2, WE_n low cycles per byte (tWP); legal range 1-15.
- WH_CYCLES, 2, WE_n high cycles per byte (tWH/tCLH/tALH); legal range 1-15.
- POST_CYCLES, 4, idle cycles after the last byte before LastStep (tADL/tWHR margin); legal range 1-63.

Ports:
- iSystemClock  in  1  clock.
- iReset  in  1  reset; synchronous, active-low.
- iStart  in  1  request; bit 3 of the ACG command vector.
- oReady  out  1  request may be accepted.
- oLastStep  out  1  one-cycle pulse when the sequence is complete.
- iTargetWay  in  NumberOfWays  one-hot way select.
- iCASelect  in  1  1 = command byte (CLE), 0 = address bytes (ALE).
- iCAData  in  40  bytes; [39:32] is sent first.
- iNumOfData  in  3  address byte count minus 1; ignored for commands.
- oPO_CE_n  out  NumberOfWays  chip enables, active-low.
- oPO_CLE  out  1  command latch enable.
- oPO_ALE  out  1  address latch enable.
- oPO_WE_n  out  1  write enable, active-low.
- oPO_DQ  out  8  data bus.
- oPO_DQ_OE  out  1  DQ output enable.

Behaviour:
- All outputs are registered.
- Reset (iReset==0 sampled at an edge), idle values: oReady=1, oLastStep=0, oPO_CE_n=all 1, CLE=0, ALE=0, WE_n=1, DQ=8'h00, DQ_OE=0, state IDLE.
- Reset mid-sequence aborts immediately to these values. No LastStep is issued.
- Byte count B:
  - Commands: B=1.
  - Addresses: B = iNumOfData+1, saturated at 5.
  - Values 5-7 of iNumOfData all give B=5.
- Accept: in IDLE, iStart==1 at an edge (edge A):
  - Latches way, select, data and B.
  - oReady=0 from edge A+1.
  - iStart while oReady==0 is ignored and not queued.
- States:
  - IDLE: oReady=1, CE_n all 1. On accept go to SETUP.
  - SETUP (1 cycle): CE_n = ~way, CLE=iCASelect, ALE=~iCASelect, DQ = byte 0, DQ_OE=1, WE_n=1. Go to WE_LOW.
  - WE_LOW (WP_CYCLES): WE_n=0, DQ = current byte. Go to WE_HIGH.
  - WE_HIGH (WH_CYCLES): WE_n=1, DQ held.
    - If bytes remain: advance the byte index and go to WE_LOW. DQ changes to the next byte on the same edge WE_n falls.
    - Otherwise go to HOLD.
  - HOLD (POST_CYCLES): CLE=ALE=0, DQ_OE=0, DQ=00h, CE_n still asserted. Go to DONE.
  - DONE (1 cycle): oLastStep=1, CE_n all 1. Next state IDLE, with oReady=1 at the following edge.
- Latency:
  - DONE is entered at edge A+2+B*(WP_CYCLES+WH_CYCLES)+POST_CYCLES.
  - With defaults: B=1 gives A+10; B=5 gives A+26.
- Counters:
  - One phase counter, 6 bits, counting down to 1 and reloaded on each state entry.
  - One 3-bit byte index; the byte is selected from iCAData by index, MSB byte first.
- A new iStart in the DONE cycle is ignored, because oReady is still 0.
- If iTargetWay is all-zero, the sequence runs normally with no CE asserted.

Optional Feature:
- Macro: NFC_ACS_CE_HOLD_EN.
- Defined:
  - DONE and IDLE keep CE_n of the last way asserted until reset, or until an accept with a different iTargetWay.
  - On a different-way accept, CE_n switches at SETUP, with CE_n all 1 for the SETUP cycle itself. This means SETUP lasts 2 cycles in that case, and latency grows by 1.
- Undefined: CE_n is released in DONE as described above.

Test Plan:
- Command EFh, way 4'b0001, defaults:
  - CE_n[0] low A+1..A+9.
  - CLE high A+1..A+5.
  - One WE_n low pulse A+2..A+3 with DQ=EFh.
  - oLastStep high only in cycle A+10.
  - oReady=1 at A+11.
- Address, iNumOfData=4, iCAData=40'h01_02_03_04_05:
  - ALE high throughout the byte phase.
  - 5 WE_n pulses with DQ 01,02,03,04,05 in order.
  - LastStep at A+26.
- iNumOfData=7: exactly 5 WE_n pulses, LastStep at A+26.
- iStart held high continuously:
  - Second accept occurs only at the edge where oReady=1 (A+11).
  - No extra WE_n pulses.
- iReset driven low during the 3rd address byte:
  - Next edge: all outputs at idle values.
  - No oLastStep.
  - oReady=1.
- With NFC_ACS_CE_HOLD_EN: two commands to way 0 keep CE_n[0] low between them; a following command to way 2 releases CE_n[0] and asserts CE_n[2] one cycle later.
